laser_point_player: RTL and testbench
=====================================

# laser_point_player

Buffers a stream of RGB laser points and plays them out one at a time, holding each point's colour for a fixed dwell period and then forcing a blanking gap. Its three 8-bit outputs feed the `value` inputs of the red, green and blue `pwm` channels. Upstream is the network/frame receive logic, which pushes points over a valid/ready handshake.

## Interface
Parameters:
- `FIFO_DEPTH`, 8 — point buffer depth; power of two, ≥2.
- `DWELL_CYCLES`, 500 — cycles each point is driven (5 µs at 100 MHz); ≥1.
- `BLANK_CYCLES`, 20 — cycles of all-zero output after each point; ≥1.

Ports:
- `clock_in`  input  1  — single clock.
- `reset_in`  input  1  — synchronous, active-high.
- `enable`  input  1  — playback permitted to start a new point.
- `in_valid`  input  1  — upstream point valid.
- `in_ready`  output  1  — block accepts a point (FIFO not full).
- `in_rgb`  input  24  — point colour: `[23:16]` red, `[15:8]` green, `[7:0]` blue.
- `in_last`  input  1  — point is the final point of a frame.
- `red_value`  output  8  — to red `pwm.value`.
- `green_value`  output  8  — to green `pwm.value`.
- `blue_value`  output  8  — to blue `pwm.value`.
- `busy`  output  1  — state is not IDLE.
- `frame_done`  output  1  — one-cycle pulse at the end of a last point's dwell.
- `underflow`  output  1  — one-cycle pulse on mid-frame starvation.

## Operation
- Transfer on `in_valid && in_ready` at a rising edge. Each entry is 25 bits: `{in_last, in_rgb}`.
- `in_ready = !full`. It is held 0 while `reset_in` is high.
- The FIFO supports push and pop in the same cycle; the count is unchanged. A push is never accepted while full, and a pop is never issued while empty.
- FSM states: IDLE, HOLD, BLANK.
- **IDLE:** outputs 0. If `enable && !empty`: pop the head into the output registers, clear `dwell_cnt`, go to HOLD.
- **HOLD:** outputs = the popped point. `dwell_cnt` increments. At `dwell_cnt == DWELL_CYCLES-1`:
  - outputs go to 0;
  - clear `blank_cnt`;
  - go to BLANK;
  - if the point's `last` flag is set, pulse `frame_done` in the cycle BLANK is entered.
- **BLANK:** outputs 0. At `blank_cnt == BLANK_CYCLES-1`:
  - if `enable && !empty`: pop the next point and go to HOLD (back-to-back);
  - else if `empty` and the previous point was not `last`: pulse `underflow`, go to IDLE;
  - else go to IDLE.
- Deasserting `enable` mid-HOLD or mid-BLANK does not truncate anything: the current dwell and blank complete, then the FSM goes to IDLE.
- Counter widths are `$clog2(N)` with a minimum of 1. Counters never wrap, because they are cleared on every state entry.
- `busy = (state != IDLE)`.

## Timing
- Reset values: all colour outputs 0; `busy`, `frame_done`, `underflow` 0; FIFO empty; state IDLE; counters 0. `in_ready` becomes 1 on the first cycle after reset deasserts.
- Reset mid-operation flushes the FIFO and returns all outputs to their reset values at the next edge. No `frame_done` or `underflow` pulse is generated.
- Latency: a point accepted at edge N, arriving while IDLE and enabled, appears on the outputs after edge N+1.
- Each point is visible for exactly `DWELL_CYCLES` cycles, followed by exactly `BLANK_CYCLES` zero cycles. The back-to-back period is `DWELL_CYCLES+BLANK_CYCLES`.
- All outputs are registered; there are no combinational paths from inputs to colour outputs.

## Structure
- Package `laser_pkg`:
  - `rgb_point_t` packed struct `{red, green, blue}`, 8 bits each;
  - `player_state_t` enum `{IDLE, HOLD, BLANK}`.
- Sub-module `point_fifo`: synchronous FIFO parameterised by `WIDTH` and `DEPTH`, with `full`/`empty` flags and an extra count bit so full and empty are distinguishable. The FSM and counters live in `laser_point_player`.

## Test plan
- **Single point.** `DWELL_CYCLES=4`, `BLANK_CYCLES=2`; push `0xFF8000` with `last=1` while enabled. Required: outputs `FF/80/00` for exactly 4 cycles starting 2 cycles after acceptance; then 2 cycles of zero; `frame_done` pulses once; `underflow` stays 0; then IDLE.
- **Back-to-back.** Three points pushed at once, last flag only on the third. Required: the pattern repeats with a 6-cycle period, there are no extra idle cycles, and `frame_done` pulses only after the third point's dwell.
- **FIFO full.** `FIFO_DEPTH=4`, `enable=0`; push 5 points. Required: `in_ready` drops after 4 acceptances. Raise `enable`: all 4 points play in order and `in_ready` reasserts after the first pop.
- **Underflow.** Push one point with `last=0`, then stop. Required: `underflow` pulses for 1 cycle at the end of BLANK, and outputs stay 0 in IDLE.
- **Enable drop.** Deassert `enable` mid-HOLD with 2 points queued. Required: the current point completes its full dwell and blank, the FSM goes to IDLE, and 1 point remains queued.
- **Reset mid-HOLD.** Assert `reset_in` during HOLD. Required: outputs are 0 at the next edge, the FIFO is empty, and no pulses are generated.

Source files
------------

// File: rtl/laser_pkg.sv
// Shared types for the laser point player: colour point layout and FSM states.
package laser_pkg;

  // One laser point colour, red in the most significant byte.
  typedef struct packed {
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
  } rgb_point_t;

  // Playback states: waiting for a point, driving a point, forced dark gap.
  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    BLANK
  } player_state_t;

  // Width of the buffered entry: last flag on top of the colour.
  localparam int ENTRY_WIDTH = 25;

endpackage

// File: rtl/point_fifo.sv
// Synchronous FIFO with a fall-through read port. The pointers carry one
// extra wrap bit so that full and empty can be told apart.
module point_fifo #(
  parameter int WIDTH = 25,
  parameter int DEPTH = 8
) (
  input  logic             clock_in,
  input  logic             reset_in,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  // Advance the read and write pointers; reset empties the buffer.
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Store accepted entries; storage contents need no reset.
  always_ff @(posedge clock_in) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/laser_point_player.sv
// Plays buffered RGB laser points one at a time: each point is held for a
// fixed dwell, followed by a forced all-dark blanking gap.
module laser_point_player #(
  parameter int FIFO_DEPTH   = 8,
  parameter int DWELL_CYCLES = 500,
  parameter int BLANK_CYCLES = 20
) (
  input  logic        clock_in,
  input  logic        reset_in,
  input  logic        enable,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [23:0] in_rgb,
  input  logic        in_last,
  output logic [7:0]  red_value,
  output logic [7:0]  green_value,
  output logic [7:0]  blue_value,
  output logic        busy,
  output logic        frame_done,
  output logic        underflow
);

  import laser_pkg::*;

  localparam int DWELL_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam int BLANK_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);
  localparam logic [BLANK_W-1:0] BLANK_LAST = BLANK_W'(BLANK_CYCLES - 1);

  player_state_t          state;
  logic [DWELL_W-1:0]     dwell_cnt;
  logic [BLANK_W-1:0]     blank_cnt;
  logic                   last_q;
  logic                   full;
  logic                   empty;
  logic                   push;
  logic                   pop;
  logic [ENTRY_WIDTH-1:0] head;
  rgb_point_t             head_point;

  assign in_ready   = !full && !reset_in;
  assign push       = in_valid && in_ready;
  assign head_point = head[23:0];
  assign busy       = (state != IDLE);

  // A new point is taken when idle, or right at the end of a blanking gap.
  assign pop = enable && !empty &&
               ((state == IDLE) || ((state == BLANK) && (blank_cnt == BLANK_LAST)));

  point_fifo #(
    .WIDTH(ENTRY_WIDTH),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clock_in (clock_in),
    .reset_in (reset_in),
    .push     (push),
    .push_data({in_last, in_rgb}),
    .pop      (pop),
    .pop_data (head),
    .full     (full),
    .empty    (empty)
  );

  // Playback FSM with registered colour outputs, counters and event pulses.
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state       <= IDLE;
      dwell_cnt   <= '0;
      blank_cnt   <= '0;
      last_q      <= 1'b0;
      red_value   <= '0;
      green_value <= '0;
      blue_value  <= '0;
      frame_done  <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      underflow  <= 1'b0;
      case (state)
        IDLE: begin
          red_value   <= '0;
          green_value <= '0;
          blue_value  <= '0;
          if (pop) begin
            red_value   <= head_point.red;
            green_value <= head_point.green;
            blue_value  <= head_point.blue;
            last_q      <= head[24];
            dwell_cnt   <= '0;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (dwell_cnt == DWELL_LAST) begin
            red_value   <= '0;
            green_value <= '0;
            blue_value  <= '0;
            blank_cnt   <= '0;
            frame_done  <= last_q;
            state       <= BLANK;
          end else begin
            dwell_cnt <= dwell_cnt + 1'b1;
          end
        end
        BLANK: begin
          if (blank_cnt == BLANK_LAST) begin
            if (pop) begin
              red_value   <= head_point.red;
              green_value <= head_point.green;
              blue_value  <= head_point.blue;
              last_q      <= head[24];
              dwell_cnt   <= '0;
              state       <= HOLD;
            end else begin
              underflow <= empty && !last_q;
              state     <= IDLE;
            end
          end else begin
            blank_cnt <= blank_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_laser_point_player.sv
// Directed bench for laser_point_player with a short dwell and blank.
module tb_laser_point_player;

  localparam int FIFO_DEPTH   = 4;
  localparam int DWELL_CYCLES = 4;
  localparam int BLANK_CYCLES = 2;

  logic        clock_in = 1'b0;
  logic        reset_in;
  logic        enable;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_rgb;
  logic        in_last;
  logic [7:0]  red_value;
  logic [7:0]  green_value;
  logic [7:0]  blue_value;
  logic        busy;
  logic        frame_done;
  logic        underflow;

  int total = 0;
  int bad   = 0;

  logic [26:0] obs;
  assign obs = {red_value, green_value, blue_value, busy, frame_done, underflow};

  laser_point_player #(
    .FIFO_DEPTH  (FIFO_DEPTH),
    .DWELL_CYCLES(DWELL_CYCLES),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) dut (
    .clock_in   (clock_in),
    .reset_in   (reset_in),
    .enable     (enable),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_rgb     (in_rgb),
    .in_last    (in_last),
    .red_value  (red_value),
    .green_value(green_value),
    .blue_value (blue_value),
    .busy       (busy),
    .frame_done (frame_done),
    .underflow  (underflow)
  );

  // Free-running 100 MHz clock.
  always #5 clock_in = ~clock_in;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reset holds everything at zero and keeps the input closed.
  task automatic test_reset();
    reset_in = 1'b1;
    enable   = 1'b0;
    in_valid = 1'b0;
    in_rgb   = '0;
    in_last  = 1'b0;
    repeat (2) @(negedge clock_in);
    total++;
    if (obs !== 27'd0) begin
      bad++;
      $display("[TB] FAIL reset_outputs: got %h want %h", obs, 27'd0);
    end
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_ready: got %b want 0", in_ready);
    end
    reset_in = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL ready_after_reset: got %b want 1", in_ready);
    end
  endtask

  // One last-flagged point: 4 cycles of colour, 2 dark, frame_done once.
  task automatic test_single_point();
    logic [26:0] expv;
    enable   = 1'b1;
    in_valid = 1'b1;
    in_rgb   = 24'hFF8000;
    in_last  = 1'b1;
    for (int cyc = 1; cyc <= 9; cyc++) begin
      @(negedge clock_in);
      expv = '0;
      if (cyc >= 2 && cyc <= 5) expv = {24'hFF8000, 3'b100};
      else if (cyc == 6)        expv = {24'h000000, 3'b110};
      else if (cyc == 7)        expv = {24'h000000, 3'b100};
      total++;
      if (obs !== expv) begin
        bad++;
        $display("[TB] FAIL single_point cyc %0d: got %h want %h", cyc, obs, expv);
      end
      in_valid = 1'b0;
    end
  endtask

  // Three points queued together play with a 6-cycle period.
  task automatic test_back_to_back();
    logic [23:0] pts [3];
    logic [26:0] expv;
    pts[0] = 24'h112233;
    pts[1] = 24'h445566;
    pts[2] = 24'h778899;
    enable   = 1'b1;
    in_valid = 1'b1;
    in_rgb   = pts[0];
    in_last  = 1'b0;
    for (int cyc = 1; cyc <= 21; cyc++) begin
      @(negedge clock_in);
      expv = '0;
      for (int p = 0; p < 3; p++) begin
        if (cyc >= 2 + 6 * p && cyc <= 5 + 6 * p) expv = {pts[p], 3'b100};
        else if (cyc == 6 + 6 * p)                expv = {24'h0, 1'b1, (p == 2), 1'b0};
        else if (cyc == 7 + 6 * p)                expv = {24'h0, 3'b100};
      end
      total++;
      if (obs !== expv) begin
        bad++;
        $display("[TB] FAIL back_to_back cyc %0d: got %h want %h", cyc, obs, expv);
      end
      if (cyc < 3) begin
        in_rgb  = pts[cyc];
        in_last = (cyc == 2);
      end else begin
        in_valid = 1'b0;
      end
    end
  endtask

  // Fill the buffer while disabled, then drain it in order.
  task automatic test_fifo_full();
    logic [26:0] expv;
    logic [23:0] colour;
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (in_ready !== (i < 4)) begin
        bad++;
        $display("[TB] FAIL fill_ready %0d: got %b want %b", i, in_ready, (i < 4));
      end
      in_valid = 1'b1;
      in_rgb   = 24'(24'h0A0B0C + 24'h010101 * i);
      in_last  = (i == 3);
      @(negedge clock_in);
    end
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL full_ready: got %b want 0", in_ready);
    end
    in_valid = 1'b0;
    total++;
    if (obs !== 27'd0) begin
      bad++;
      $display("[TB] FAIL full_idle: got %h want %h", obs, 27'd0);
    end
    enable = 1'b1;
    for (int cyc = 1; cyc <= 26; cyc++) begin
      @(negedge clock_in);
      expv = '0;
      for (int p = 0; p < 4; p++) begin
        colour = 24'(24'h0A0B0C + 24'h010101 * p);
        if (cyc >= 1 + 6 * p && cyc <= 4 + 6 * p) expv = {colour, 3'b100};
        else if (cyc == 5 + 6 * p)                expv = {24'h0, 1'b1, (p == 3), 1'b0};
        else if (cyc == 6 + 6 * p)                expv = {24'h0, 3'b100};
      end
      total++;
      if (obs !== expv) begin
        bad++;
        $display("[TB] FAIL drain cyc %0d: got %h want %h", cyc, obs, expv);
      end
      if (cyc == 1) begin
        total++;
        if (in_ready !== 1'b1) begin
          bad++;
          $display("[TB] FAIL ready_after_pop: got %b want 1", in_ready);
        end
      end
    end
  endtask

  // A non-last point with nothing behind it ends in an underflow pulse.
  task automatic test_underflow();
    logic [26:0] expv;
    enable   = 1'b1;
    in_valid = 1'b1;
    in_rgb   = 24'h123456;
    in_last  = 1'b0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clock_in);
      expv = '0;
      if (cyc >= 2 && cyc <= 5)     expv = {24'h123456, 3'b100};
      else if (cyc == 6 || cyc == 7) expv = {24'h000000, 3'b100};
      else if (cyc == 8)            expv = {24'h000000, 3'b001};
      total++;
      if (obs !== expv) begin
        bad++;
        $display("[TB] FAIL underflow cyc %0d: got %h want %h", cyc, obs, expv);
      end
      in_valid = 1'b0;
    end
  endtask

  // Dropping enable mid-dwell finishes the point and leaves one queued.
  task automatic test_enable_drop();
    logic [26:0] expv;
    enable   = 1'b1;
    in_valid = 1'b1;
    in_rgb   = 24'hA1B2C3;
    in_last  = 1'b0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clock_in);
      expv = '0;
      if (cyc >= 2 && cyc <= 5)     expv = {24'hA1B2C3, 3'b100};
      else if (cyc == 6 || cyc == 7) expv = {24'h000000, 3'b100};
      total++;
      if (obs !== expv) begin
        bad++;
        $display("[TB] FAIL enable_drop cyc %0d: got %h want %h", cyc, obs, expv);
      end
      if (cyc == 1) in_rgb = 24'hD4E5F6;
      if (cyc == 2) in_valid = 1'b0;
      if (cyc == 3) enable = 1'b0;
    end
    enable = 1'b1;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clock_in);
      expv = '0;
      if (cyc >= 1 && cyc <= 4)     expv = {24'hD4E5F6, 3'b100};
      else if (cyc == 5 || cyc == 6) expv = {24'h000000, 3'b100};
      else if (cyc == 7)            expv = {24'h000000, 3'b001};
      total++;
      if (obs !== expv) begin
        bad++;
        $display("[TB] FAIL resume cyc %0d: got %h want %h", cyc, obs, expv);
      end
    end
  endtask

  // Reset during a dwell blanks at once, flushes the queue, no pulses.
  task automatic test_reset_mid_hold();
    logic [26:0] expv;
    enable   = 1'b1;
    in_valid = 1'b1;
    in_rgb   = 24'h0F0F0F;
    in_last  = 1'b1;
    for (int cyc = 1; cyc <= 3; cyc++) begin
      @(negedge clock_in);
      expv = (cyc == 1) ? 27'd0 : {24'h0F0F0F, 3'b100};
      total++;
      if (obs !== expv) begin
        bad++;
        $display("[TB] FAIL pre_reset cyc %0d: got %h want %h", cyc, obs, expv);
      end
      if (cyc == 1) in_rgb = 24'hF0F0F0;
      else          in_valid = 1'b0;
    end
    reset_in = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL ready_in_reset: got %b want 0", in_ready);
    end
    @(negedge clock_in);
    total++;
    if (obs !== 27'd0) begin
      bad++;
      $display("[TB] FAIL reset_mid_hold: got %h want %h", obs, 27'd0);
    end
    reset_in = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL ready_post_reset: got %b want 1", in_ready);
    end
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clock_in);
      total++;
      if (obs !== 27'd0) begin
        bad++;
        $display("[TB] FAIL flushed cyc %0d: got %h want %h", cyc, obs, 27'd0);
      end
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    test_reset();
    test_single_point();
    test_back_to_back();
    test_fifo_full();
    test_underflow();
    test_enable_drop();
    test_reset_mid_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
